// File: rtl/secuenciador_ventana_pkg.sv
// Shared constants for the window-read sequencer: register map, command/status
// bit positions and FSM state encoding.
package secuenciador_ventana_pkg;

    localparam logic [2:0] REG_INICIO    = 3'd0;
    localparam logic [2:0] REG_LECTURAS  = 3'd1;
    localparam logic [2:0] REG_FILAS     = 3'd2;
    localparam logic [2:0] REG_PASO      = 3'd3;
    localparam logic [2:0] REG_BUFFERS   = 3'd4;
    localparam logic [2:0] REG_COMANDO   = 3'd5;
    localparam logic [2:0] REG_ESTADO    = 3'd6;
    localparam logic [2:0] REG_RESERVADO = 3'd7;

    localparam int CMD_START          = 0;
    localparam int CMD_ABORT          = 1;
    localparam int STS_OCUPADO        = 0;
    localparam int STS_ERROR          = 1;
    localparam int STS_LIMPIAR_ERROR  = 2;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        LECTURA  = 2'd1,
        FIN_FILA = 2'd2,
        HECHO    = 2'd3
    } estado_t;

endpackage

// File: rtl/secuenciador_ventana_ffd.sv
// Enabled D register with asynchronous active-high clear; used for every
// visible configuration register and its shadow copy.
module FlipFlopD_Habilitado #(
    parameter int ANCHO = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             habilitacion,
    input  logic [ANCHO-1:0] d,
    output logic [ANCHO-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (habilitacion) begin
            q <= d;
        end
    end

endmodule

// File: rtl/secuenciador_ventana.sv
// Window-read sequencer: instruction-bus register file plus an FSM that issues
// row-by-row memory reads tagged with a rotating line-buffer index.
//
// state    | meaning
// REPOSO   | idle, waiting for a start command
// LECTURA  | requesting words of the current row
// FIN_FILA | one-cycle row advance: base += stride, rotate buffer index
// HECHO    | one-cycle completion pulse, then back to REPOSO
module secuenciador_ventana
    import secuenciador_ventana_pkg::*;
#(
    parameter int BITS_BUS_DATOS_INSTR     = 21,
    parameter int BITS_BUS_DIRECCION_INSTR = 11,
    parameter int BITS_BUFFERS_IMAGEN      = 2,
    parameter int BITS_CONTADOR            = 12
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [BITS_BUS_DIRECCION_INSTR-1:0] direccion_registros,
    input  logic [BITS_BUS_DATOS_INSTR-1:0]     datos_registros,
    input  logic                                habilitacion_registros,
    output logic [BITS_BUS_DATOS_INSTR-1:0]     datos_lectura_registros,
    output logic                                solicitud_valida,
    output logic [BITS_BUS_DATOS_INSTR-1:0]     direccion_mem,
    input  logic                                mem_listo,
    output logic [BITS_BUFFERS_IMAGEN-1:0]      indice_buffer,
    output logic                                ultimo_fila,
    output logic                                ocupado,
    output logic                                hecho
);

    localparam int BD = BITS_BUS_DATOS_INSTR;
    localparam int BC = BITS_CONTADOR;
    localparam int BB = BITS_BUFFERS_IMAGEN;

    estado_t estado, estado_sig;

    logic [2:0] sel;
    logic       escribe_inicio, escribe_lecturas, escribe_filas, escribe_paso, escribe_buffers;
    logic       cmd_start, cmd_abort, limpiar_error, arranque, sin_trabajo;

    logic [BD-1:0] inicio_q, paso_q, inicio_sh, paso_sh;
    logic [BC-1:0] lecturas_q, filas_q, lecturas_sh, filas_sh;
    logic [BB-1:0] buffers_q, buffers_sh;

    logic [BD-1:0] desplazamiento;
    logic [BC-1:0] palabra, fila;
    logic [BB-1:0] indice, indice_sig;
    logic          abort_pendiente, error_sticky;
    logic          ultima_palabra, ultima_fila;

    logic unused_bits;
    assign unused_bits = ^direccion_registros[BITS_BUS_DIRECCION_INSTR-1:3];

    assign sel              = direccion_registros[2:0];
    assign escribe_inicio   = habilitacion_registros && (sel == REG_INICIO);
    assign escribe_lecturas = habilitacion_registros && (sel == REG_LECTURAS);
    assign escribe_filas    = habilitacion_registros && (sel == REG_FILAS);
    assign escribe_paso     = habilitacion_registros && (sel == REG_PASO);
    assign escribe_buffers  = habilitacion_registros && (sel == REG_BUFFERS);
    assign cmd_start     = habilitacion_registros && (sel == REG_COMANDO) && datos_registros[CMD_START];
    assign cmd_abort     = habilitacion_registros && (sel == REG_COMANDO) && datos_registros[CMD_ABORT];
    assign limpiar_error = habilitacion_registros && (sel == REG_ESTADO) && datos_registros[STS_LIMPIAR_ERROR];

    // Abort wins over a simultaneous start; shadows capture on the accepted start edge.
    assign arranque    = (estado == REPOSO) && cmd_start && !cmd_abort;
    assign sin_trabajo = (lecturas_q == '0) || (filas_q == '0);

    FlipFlopD_Habilitado #(.ANCHO(BD)) u_inicio   (.clk(clk), .reset(reset), .habilitacion(escribe_inicio),   .d(datos_registros),         .q(inicio_q));
    FlipFlopD_Habilitado #(.ANCHO(BC)) u_lecturas (.clk(clk), .reset(reset), .habilitacion(escribe_lecturas), .d(datos_registros[BC-1:0]), .q(lecturas_q));
    FlipFlopD_Habilitado #(.ANCHO(BC)) u_filas    (.clk(clk), .reset(reset), .habilitacion(escribe_filas),    .d(datos_registros[BC-1:0]), .q(filas_q));
    FlipFlopD_Habilitado #(.ANCHO(BD)) u_paso     (.clk(clk), .reset(reset), .habilitacion(escribe_paso),     .d(datos_registros),         .q(paso_q));
    FlipFlopD_Habilitado #(.ANCHO(BB)) u_buffers  (.clk(clk), .reset(reset), .habilitacion(escribe_buffers),  .d(datos_registros[BB-1:0]), .q(buffers_q));

    FlipFlopD_Habilitado #(.ANCHO(BD)) u_inicio_sh   (.clk(clk), .reset(reset), .habilitacion(arranque), .d(inicio_q),   .q(inicio_sh));
    FlipFlopD_Habilitado #(.ANCHO(BC)) u_lecturas_sh (.clk(clk), .reset(reset), .habilitacion(arranque), .d(lecturas_q), .q(lecturas_sh));
    FlipFlopD_Habilitado #(.ANCHO(BC)) u_filas_sh    (.clk(clk), .reset(reset), .habilitacion(arranque), .d(filas_q),    .q(filas_sh));
    FlipFlopD_Habilitado #(.ANCHO(BD)) u_paso_sh     (.clk(clk), .reset(reset), .habilitacion(arranque), .d(paso_q),     .q(paso_sh));
    FlipFlopD_Habilitado #(.ANCHO(BB)) u_buffers_sh  (.clk(clk), .reset(reset), .habilitacion(arranque), .d(buffers_q),  .q(buffers_sh));

    assign ultima_palabra = (palabra == lecturas_sh - BC'(1));
    assign ultima_fila    = (fila == filas_sh - BC'(1));
    // A buffer count of 0 or 1 pins the index at 0.
    assign indice_sig = ((buffers_sh <= BB'(1)) || (indice >= buffers_sh - BB'(1))) ? '0 : indice + BB'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO: begin
                if (arranque) begin
                    estado_sig = sin_trabajo ? HECHO : LECTURA;
                end
            end
            LECTURA: begin
                if (mem_listo) begin
                    if (abort_pendiente || cmd_abort) begin
                        estado_sig = HECHO;
                    end else if (ultima_palabra) begin
                        estado_sig = FIN_FILA;
                    end
                end
            end
            FIN_FILA: begin
                if (cmd_abort || ultima_fila) begin
                    estado_sig = HECHO;
                end else begin
                    estado_sig = LECTURA;
                end
            end
            HECHO:   estado_sig = REPOSO;
            default: estado_sig = REPOSO;
        endcase
    end

    always_comb begin
        solicitud_valida = (estado == LECTURA);
        ocupado          = (estado == LECTURA) || (estado == FIN_FILA);
        hecho            = (estado == HECHO);
        ultimo_fila      = (estado == LECTURA) && ultima_palabra;
        direccion_mem    = inicio_sh + desplazamiento + BD'(palabra);
        indice_buffer    = indice;
    end

    // Row/buffer progress lives only inside a sequence; idle and done states wipe it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            desplazamiento  <= '0;
            palabra         <= '0;
            fila            <= '0;
            indice          <= '0;
            abort_pendiente <= 1'b0;
        end else begin
            case (estado)
                LECTURA: begin
                    if (cmd_abort) begin
                        abort_pendiente <= 1'b1;
                    end
                    if (mem_listo) begin
                        palabra <= palabra + BC'(1);
                    end
                end
                FIN_FILA: begin
                    palabra        <= '0;
                    desplazamiento <= desplazamiento + paso_sh;
                    fila           <= fila + BC'(1);
                    indice         <= indice_sig;
                end
                default: begin
                    desplazamiento  <= '0;
                    palabra         <= '0;
                    fila            <= '0;
                    indice          <= '0;
                    abort_pendiente <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_sticky <= 1'b0;
        end else if (cmd_start && ocupado) begin
            error_sticky <= 1'b1;
        end else if (limpiar_error) begin
            error_sticky <= 1'b0;
        end
    end

    always_comb begin
        datos_lectura_registros = '0;
        case (sel)
            REG_INICIO:   datos_lectura_registros = inicio_q;
            REG_LECTURAS: datos_lectura_registros = BD'(lecturas_q);
            REG_FILAS:    datos_lectura_registros = BD'(filas_q);
            REG_PASO:     datos_lectura_registros = paso_q;
            REG_BUFFERS:  datos_lectura_registros = BD'(buffers_q);
            REG_ESTADO: begin
                datos_lectura_registros[STS_OCUPADO] = ocupado;
                datos_lectura_registros[STS_ERROR]   = error_sticky;
            end
            default:      datos_lectura_registros = '0;
        endcase
    end

endmodule

// File: tb/tb_secuenciador_ventana.sv
// Self-checking bench for secuenciador_ventana: a queue of expected requests
// built from the window parameters, checked on every accepted handshake.
module tb_secuenciador_ventana;

    logic        clk;
    logic        reset;
    logic [10:0] direccion_registros;
    logic [20:0] datos_registros;
    logic        habilitacion_registros;
    logic [20:0] datos_lectura_registros;
    logic        solicitud_valida;
    logic [20:0] direccion_mem;
    logic        mem_listo;
    logic [1:0]  indice_buffer;
    logic        ultimo_fila;
    logic        ocupado;
    logic        hecho;

    secuenciador_ventana dut (
        .clk                     (clk),
        .reset                   (reset),
        .direccion_registros     (direccion_registros),
        .datos_registros         (datos_registros),
        .habilitacion_registros  (habilitacion_registros),
        .datos_lectura_registros (datos_lectura_registros),
        .solicitud_valida        (solicitud_valida),
        .direccion_mem           (direccion_mem),
        .mem_listo               (mem_listo),
        .indice_buffer           (indice_buffer),
        .ultimo_fila             (ultimo_fila),
        .ocupado                 (ocupado),
        .hecho                   (hecho)
    );

    typedef struct packed {
        logic [20:0] addr;
        logic [1:0]  idx;
        logic        last;
    } req_t;

    req_t exp_q[$];
    req_t e_mon;

    int checks = 0, passed = 0;
    int mon_checks = 0, mon_passed = 0;
    int hecho_cnt = 0;
    int h_base = 0;
    bit mon_on = 0;
    int ready_mode = 0;
    bit stalled = 0;
    logic [20:0] prev_addr;
    logic [1:0]  prev_idx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mem_listo: 0 = always ready, 1 = random, 2 = never ready
    initial begin
        mem_listo = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       mem_listo = 1'b1;
                1:       mem_listo = 1'($urandom_range(0, 1));
                default: mem_listo = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!mon_on) begin
            stalled = 0;
        end else begin
            if (hecho) hecho_cnt++;
            if (stalled) begin
                mon_checks++;
                if (solicitud_valida === 1'b1 && direccion_mem === prev_addr && indice_buffer === prev_idx)
                    mon_passed++;
                else
                    $display("FAIL hold: valid=%b addr=%h idx=%0d, required valid=1 addr=%h idx=%0d",
                             solicitud_valida, direccion_mem, indice_buffer, prev_addr, prev_idx);
            end
            if (solicitud_valida && mem_listo) begin
                mon_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL req_extra: addr=%h idx=%0d, required no request", direccion_mem, indice_buffer);
                end else begin
                    e_mon = exp_q.pop_front();
                    if (direccion_mem === e_mon.addr && indice_buffer === e_mon.idx && ultimo_fila === e_mon.last)
                        mon_passed++;
                    else
                        $display("FAIL req: addr=%h idx=%0d last=%b, required addr=%h idx=%0d last=%b",
                                 direccion_mem, indice_buffer, ultimo_fila, e_mon.addr, e_mon.idx, e_mon.last);
                end
            end
            stalled   = solicitud_valida && !mem_listo;
            prev_addr = direccion_mem;
            prev_idx  = indice_buffer;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", nm, got, req);
    endtask

    task automatic wr(input int a, input logic [20:0] d);
        @(posedge clk);
        #1;
        direccion_registros    = 11'(a);
        datos_registros        = d;
        habilitacion_registros = 1'b1;
        @(posedge clk);
        #1;
        habilitacion_registros = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input int a, input logic [20:0] req);
        direccion_registros = 11'(a);
        #1;
        chk(nm, 32'(datos_lectura_registros), 32'(req));
    endtask

    task automatic cfg(input logic [20:0] ini, input int lect, input int filas,
                       input logic [20:0] paso, input int bufs);
        logic [20:0] base;
        req_t e;
        wr(0, ini);
        wr(1, 21'(lect));
        wr(2, 21'(filas));
        wr(3, paso);
        wr(4, 21'(bufs));
        exp_q.delete();
        base = ini;
        for (int r = 0; r < filas; r++) begin
            for (int w = 0; w < lect; w++) begin
                e.addr = base + 21'(w);
                e.idx  = (bufs <= 1) ? 2'd0 : 2'(r % bufs);
                e.last = (w == lect - 1);
                exp_q.push_back(e);
            end
            base = base + paso;
        end
    endtask

    task automatic go(input int mode);
        ready_mode = mode;
        h_base     = hecho_cnt;
        wr(5, 21'h1);
    endtask

    task automatic fin(input string nm);
        int n = 0;
        while (hecho_cnt == h_base && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({nm, "_hecho_seen"}, 32'(hecho_cnt - h_base), 32'd1);
        chk({nm, "_ocupado_after"}, 32'(ocupado), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk({nm, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        chk({nm, "_hecho_once"}, 32'(hecho_cnt - h_base), 32'd1);
    endtask

    initial begin
        int h;
        reset = 1'b0;
        direccion_registros = '0;
        datos_registros = '0;
        habilitacion_registros = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_valid", 32'(solicitud_valida), 0);
        chk("rst_ocupado", 32'(ocupado), 0);
        chk("rst_hecho", 32'(hecho), 0);
        chk("rst_idx", 32'(indice_buffer), 0);
        chk("rst_ultimo", 32'(ultimo_fila), 0);
        rd_chk("rst_reg_lecturas", 1, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mon_on = 1;

        // 1: basic 4x3 window, three buffers, memory always ready
        cfg(21'h100, 4, 3, 21'h40, 3);
        go(0);
        chk("t1_first_valid", 32'(solicitud_valida), 1);
        chk("t1_first_addr", 32'(direccion_mem), 32'h100);
        chk("t1_first_idx", 32'(indice_buffer), 0);
        fin("t1");
        rd_chk("t1_reg_paso", 3, 21'h40);
        rd_chk("t1_reg_reserved", 7, 0);

        // 2: same window with random back-pressure
        cfg(21'h100, 4, 3, 21'h40, 3);
        go(1);
        fin("t2");

        // 3: five rows over two buffers -> index 0,1,0,1,0
        cfg(21'h000, 2, 5, 21'h10, 2);
        go(0);
        fin("t3");

        // address wrap at 2^21 with buffer count 0
        cfg(21'h1FFFFE, 3, 2, 21'h000004, 0);
        go(0);
        fin("twrap");

        // 4: zero words per row -> immediate completion, no requests
        cfg(21'h010, 0, 3, 21'h40, 3);
        go(0);
        @(negedge clk);
        chk("t4_hecho_next", 32'(hecho), 1);
        chk("t4_no_valid", 32'(solicitud_valida), 0);
        fin("t4");

        // 5: restart and base rewrite mid-sequence
        cfg(21'h100, 4, 3, 21'h40, 3);
        go(0);
        repeat (2) @(posedge clk);
        wr(5, 21'h1);
        wr(0, 21'h700);
        rd_chk("t5_status_busy_err", 6, 21'h3);
        fin("t5");
        rd_chk("t5_status_idle_err", 6, 21'h2);
        wr(6, 21'h4);
        rd_chk("t5_status_cleared", 6, 21'h0);
        rd_chk("t5_reg_inicio", 0, 21'h700);

        // start and abort together in REPOSO: nothing happens
        cfg(21'h010, 2, 2, 21'h4, 1);
        exp_q.delete();
        h = hecho_cnt;
        wr(5, 21'h3);
        repeat (4) @(posedge clk);
        #1;
        chk("sa_ocupado", 32'(ocupado), 0);
        chk("sa_valid", 32'(solicitud_valida), 0);
        chk("sa_no_hecho", 32'(hecho_cnt - h), 0);

        // 6: abort while the first request is stalled
        cfg(21'h200, 4, 3, 21'h40, 3);
        exp_q.delete();
        exp_q.push_back(req_t'{addr: 21'h200, idx: 2'd0, last: 1'b0});
        go(2);
        repeat (3) @(posedge clk);
        wr(5, 21'h2);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_held_valid", 32'(solicitud_valida), 1);
        chk("t6_held_addr", 32'(direccion_mem), 32'h200);
        chk("t6_no_hecho_yet", 32'(hecho_cnt - h_base), 0);
        ready_mode = 0;
        fin("t6");

        // reset mid-row: outputs clear asynchronously, no hecho afterwards
        cfg(21'h300, 8, 2, 21'h100, 2);
        go(0);
        repeat (4) @(posedge clk);
        #3;
        mon_on = 0;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("rr_valid", 32'(solicitud_valida), 0);
        chk("rr_ocupado", 32'(ocupado), 0);
        chk("rr_hecho", 32'(hecho), 0);
        chk("rr_idx", 32'(indice_buffer), 0);
        chk("rr_ultimo", 32'(ultimo_fila), 0);
        chk("rr_addr", 32'(direccion_mem), 0);
        #12 reset = 1'b0;
        mon_on = 1;
        h = hecho_cnt;
        repeat (5) @(posedge clk);
        #1;
        chk("rr_no_hecho", 32'(hecho_cnt - h), 0);
        rd_chk("rr_reg_inicio", 0, 0);

        checks += mon_checks;
        passed += mon_passed;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
